// File: rtl/spi_ram_bridge.sv
// rtl/spi_ram_bridge.sv - SPI mode-0 slave decoding 16-bit frames into single 16x8 RAM accesses
module spi_ram_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       ram_en,
  output logic       ram_rw,
  output logic [3:0] ram_adrs,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout,
  output logic       busy,
  output logic       done,
  output logic       frame_err
);

  typedef enum logic [3:0] {
    IDLE, CMD, RD_SETUP, RD_EN, RD_CAP, DATA, WR_SETUP, WR_EN, TRAIL
  } state_t;

  state_t state_q, state_d;

  // Synchronizer chains carry no reset so a reset mid-frame cannot fake a cs_n fall.
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic sclk_prev_q, cs_prev_q;
  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_err;

  logic [4:0] cnt_q, cnt_d;
  logic [7:0] rx_q, rx_d, tx_q, tx_d, rx_byte;
  logic       miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic       ram_en_q, ram_en_d, ram_rw_q, ram_rw_d;
  logic [3:0] ram_adrs_q, ram_adrs_d;
  logic [7:0] ram_din_q, ram_din_d;
  logic       busy_q, busy_d, done_q, done_d, err_q, err_d, abort_q, abort_d;

  always_ff @(posedge clk) begin
    sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = ~cs_s & sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~cs_s & ~sclk_s & sclk_prev_q;
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign cs_err    = cs_rise && (cnt_q != 5'd0) && (cnt_q < 5'd16);
  assign rx_byte   = {rx_q[6:0], mosi_s};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    miso_oe_d  = ~cs_s;
    ram_rw_d   = ram_rw_q;
    ram_adrs_d = ram_adrs_q;
    ram_din_d  = ram_din_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    abort_d    = abort_q;

    if (state_q != IDLE && sclk_rise) begin
      if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
      rx_d = rx_byte;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = CMD;
          cnt_d   = 5'd0;
          rx_d    = 8'h00;
          tx_d    = 8'h00;
          abort_d = 1'b0;
        end
      end
      CMD: begin
        miso_d = 1'b0;
        if (cs_rise) begin
          err_d   = cs_err;
          state_d = IDLE;
        end else if (sclk_rise && cnt_q == 5'd7) begin
          ram_rw_d   = rx_byte[7];
          ram_adrs_d = rx_byte[3:0];
          state_d    = rx_byte[7] ? RD_SETUP : DATA;
        end
      end
      RD_SETUP: begin
        if (cs_err) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = RD_EN;
        end
      end
      RD_EN: begin
        // An abort here still lets the RAM read finish; the flag suppresses the shift-out.
        if (cs_err) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
        end
        state_d = RD_CAP;
      end
      RD_CAP: begin
        done_d = 1'b1;
        if (abort_q || cs_err) begin
          err_d   = cs_err;
          state_d = IDLE;
        end else begin
          tx_d    = ram_dout;
          miso_d  = ram_dout[7];
          state_d = DATA;
        end
      end
      DATA: begin
        if (cs_rise) begin
          err_d   = cs_err;
          state_d = IDLE;
        end else begin
          if (ram_rw_q && sclk_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
          if (sclk_rise && cnt_q == 5'd15) begin
            if (ram_rw_q) begin
              state_d = TRAIL;
            end else begin
              ram_din_d = rx_byte;
              state_d   = WR_SETUP;
            end
          end
        end
      end
      WR_SETUP: begin
        ram_rw_d = 1'b0;
        state_d  = WR_EN;
      end
      WR_EN: begin
        done_d   = 1'b1;
        ram_rw_d = 1'b1;
        state_d  = TRAIL;
      end
      TRAIL: begin
        miso_d = 1'b0;
        if (cs_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      ram_rw_d = 1'b1;
      miso_d   = 1'b0;
      busy_d   = 1'b0;
    end else if (state_q != IDLE && sclk_rise) begin
      busy_d = 1'b1;
    end

    // The strobe is a pure function of the next state, so it never overlaps an address/data change.
    ram_en_d = (state_d == RD_EN) || (state_d == WR_EN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      cnt_q       <= 5'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_rw_q    <= 1'b1;
      ram_adrs_q  <= 4'h0;
      ram_din_q   <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      ram_en_q    <= ram_en_d;
      ram_rw_q    <= ram_rw_d;
      ram_adrs_q  <= ram_adrs_d;
      ram_din_q   <= ram_din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      abort_q     <= abort_d;
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = miso_oe_q;
  assign ram_en    = ram_en_q;
  assign ram_rw    = ram_rw_q;
  assign ram_adrs  = ram_adrs_q;
  assign ram_din   = ram_din_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_spi_ram_bridge.sv
// tb/tb_spi_ram_bridge.sv - self-checking bench for spi_ram_bridge with a behavioural 16x8 RAM
module tb_spi_ram_bridge;

  logic       clk = 1'b0;
  logic       rst, sclk, cs_n, mosi;
  logic       miso, miso_oe, ram_en, ram_rw, busy, done, frame_err;
  logic [3:0] ram_adrs;
  logic [7:0] ram_din, ram_dout;
  logic [7:0] mem [16];

  int checks = 0;
  int failures = 0;
  int en_count = 0;
  int done_count = 0;
  int err_count = 0;

  typedef struct packed {
    logic       rw;
    logic [3:0] adrs;
    logic [7:0] din;
  } acc_t;

  acc_t       exp_acc[$];
  logic [7:0] exp_rd[$];

  logic       prev_rw;
  logic [3:0] prev_adrs;
  logic [7:0] prev_din;

  localparam logic [18:0] RESET_VEC = {1'b0, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  spi_ram_bridge #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .ram_en(ram_en), .ram_rw(ram_rw),
    .ram_adrs(ram_adrs), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .done(done), .frame_err(frame_err)
  );

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    ram_dout = 8'h00;
  end

  always @(posedge clk) begin
    if (ram_en && !ram_rw) mem[ram_adrs] <= ram_din;
    if (ram_en && ram_rw) ram_dout <= mem[ram_adrs];
  end

  always @(negedge clk) begin
    acc_t e;
    if (!rst) begin
      if (ram_en) begin
        en_count++;
        checks++;
        if (exp_acc.size() == 0) begin
          failures++;
          $display("FAIL ram_access unexpected: rw=%0b adrs=%0h din=%02h, required none", ram_rw, ram_adrs, ram_din);
        end else begin
          e = exp_acc.pop_front();
          if (ram_rw !== e.rw || ram_adrs !== e.adrs || (!e.rw && ram_din !== e.din)) begin
            failures++;
            $display("FAIL ram_access: rw=%0b adrs=%0h din=%02h, required rw=%0b adrs=%0h din=%02h",
                     ram_rw, ram_adrs, ram_din, e.rw, e.adrs, e.din);
          end
        end
        checks++;
        if (ram_rw !== prev_rw || ram_adrs !== prev_adrs || ram_din !== prev_din) begin
          failures++;
          $display("FAIL ram_en_stable: rw/adrs/din=%0b/%0h/%02h, required previous %0b/%0h/%02h",
                   ram_rw, ram_adrs, ram_din, prev_rw, prev_adrs, prev_din);
        end
      end
      if (done) done_count++;
      if (frame_err) err_count++;
    end
    prev_rw   = ram_rw;
    prev_adrs = ram_adrs;
    prev_din  = ram_din;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_xfer(input logic [31:0] tx, input int nbits, input int gap, output logic [31:0] rx);
    rx = '0;
    cs_n = 1'b0;
    wait_clk(10);
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[31-i];
      wait_clk(10);
      sclk = 1'b1;
      rx[31-i] = miso;
      wait_clk(10);
      sclk = 1'b0;
    end
    wait_clk(10);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clk(gap);
  endtask

  task automatic test_reset();
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    wait_clk(6);
    checks++;
    if ({ram_en, ram_rw, ram_adrs, ram_din, miso, miso_oe, busy, done, frame_err} !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_values: got %05h, required %05h",
               {ram_en, ram_rw, ram_adrs, ram_din, miso, miso_oe, busy, done, frame_err}, RESET_VEC);
    end
    rst = 1'b0;
    wait_clk(6);
    checks++;
    if (miso_oe !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: miso_oe=%0b busy=%0b, required 0 0", miso_oe, busy);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rx;
    int d0, e0;
    d0 = done_count; e0 = en_count;
    exp_acc.push_back('{1'b0, 4'h5, 8'hA5});
    spi_xfer({8'h05, 8'hA5, 16'h0}, 16, 20, rx);
    checks++;
    if (rx[31:16] !== 16'h0000) begin
      failures++;
      $display("FAIL write_miso: got %04h, required 0000", rx[31:16]);
    end
    exp_acc.push_back('{1'b1, 4'h5, 8'h00});
    exp_rd.push_back(8'hA5);
    spi_xfer({8'h85, 24'h0}, 16, 20, rx);
    checks++;
    if (rx[31:16] !== {8'h00, exp_rd[0]}) begin
      failures++;
      $display("FAIL read_back_5: got %04h, required %04h", rx[31:16], {8'h00, exp_rd[0]});
    end
    void'(exp_rd.pop_front());
    checks++;
    if (done_count - d0 != 2 || en_count - e0 != 2) begin
      failures++;
      $display("FAIL wr_rd_pulses: done=%0d en=%0d, required 2 2", done_count - d0, en_count - e0);
    end
  endtask

  task automatic test_all_addresses();
    logic [31:0] rx;
    logic [7:0]  e;
    int e0;
    e0 = en_count;
    for (int a = 0; a < 16; a++) begin
      exp_acc.push_back('{1'b0, a[3:0], 8'h10 + a[7:0]});
      spi_xfer({4'h0, a[3:0], 8'h10 + a[7:0], 16'h0}, 16, 20, rx);
    end
    for (int a = 0; a < 16; a++) begin
      exp_acc.push_back('{1'b1, a[3:0], 8'h00});
      exp_rd.push_back(8'h10 + a[7:0]);
      spi_xfer({4'h8, a[3:0], 24'h0}, 16, 20, rx);
      e = exp_rd.pop_front();
      checks++;
      if (rx[23:16] !== e) begin
        failures++;
        $display("FAIL read_all adrs=%0d: got %02h, required %02h", a, rx[23:16], e);
      end
    end
    checks++;
    if (en_count - e0 != 32) begin
      failures++;
      $display("FAIL all_en_count: got %0d, required 32", en_count - e0);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rx;
    logic [7:0]  e;
    int e0, f0;
    e0 = en_count; f0 = err_count;
    spi_xfer({8'h03, 8'h3C, 16'h0}, 12, 20, rx);
    checks++;
    if (err_count - f0 != 1 || en_count - e0 != 0) begin
      failures++;
      $display("FAIL abort_12: frame_err=%0d ram_en=%0d, required 1 0", err_count - f0, en_count - e0);
    end
    f0 = err_count;
    spi_xfer(32'h0, 0, 20, rx);
    checks++;
    if (err_count - f0 != 0) begin
      failures++;
      $display("FAIL abort_0bits: frame_err=%0d, required 0", err_count - f0);
    end
    exp_acc.push_back('{1'b1, 4'h3, 8'h00});
    exp_rd.push_back(8'h13);
    spi_xfer({8'h83, 24'h0}, 16, 20, rx);
    e = exp_rd.pop_front();
    checks++;
    if (rx[23:16] !== e) begin
      failures++;
      $display("FAIL abort_preserve: got %02h, required %02h", rx[23:16], e);
    end
  endtask

  task automatic test_busy_oe();
    int f0;
    f0 = err_count;
    cs_n = 1'b0;
    wait_clk(6);
    checks++;
    if (miso_oe !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL oe_before_sclk: miso_oe=%0b busy=%0b, required 1 0", miso_oe, busy);
    end
    sclk = 1'b1;
    wait_clk(6);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_rise: got %0b, required 1", busy);
    end
    sclk = 1'b0;
    wait_clk(10);
    cs_n = 1'b1;
    wait_clk(10);
    checks++;
    if (err_count - f0 != 1 || busy !== 1'b0 || miso_oe !== 1'b0) begin
      failures++;
      $display("FAIL abort_1bit: frame_err=%0d busy=%0b miso_oe=%0b, required 1 0 0",
               err_count - f0, busy, miso_oe);
    end
  endtask

  task automatic test_long_read();
    logic [31:0] rx;
    logic [7:0]  e;
    int e0;
    e0 = en_count;
    exp_acc.push_back('{1'b1, 4'hF, 8'h00});
    exp_rd.push_back(8'h1F);
    spi_xfer({8'h8F, 24'h0}, 32, 20, rx);
    e = exp_rd.pop_front();
    checks++;
    if (rx !== {8'h00, e, 16'h0000}) begin
      failures++;
      $display("FAIL long_read: got %08h, required %08h", rx, {8'h00, e, 16'h0000});
    end
    checks++;
    if (en_count - e0 != 1) begin
      failures++;
      $display("FAIL long_read_en: got %0d, required 1", en_count - e0);
    end
  endtask

  task automatic test_reserved();
    logic [31:0] rx;
    logic [7:0]  e;
    exp_acc.push_back('{1'b0, 4'h2, 8'h5A});
    spi_xfer({8'h72, 8'h5A, 16'h0}, 16, 20, rx);
    exp_acc.push_back('{1'b1, 4'h2, 8'h00});
    exp_rd.push_back(8'h5A);
    spi_xfer({8'h82, 24'h0}, 16, 20, rx);
    e = exp_rd.pop_front();
    checks++;
    if (rx[23:16] !== e) begin
      failures++;
      $display("FAIL reserved_bits: got %02h, required %02h", rx[23:16], e);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rx;
    logic [15:0] frame;
    logic [7:0]  e;
    int e0, f0;
    e0 = en_count; f0 = err_count;
    frame = {8'h01, 8'hEE};
    cs_n = 1'b0;
    wait_clk(10);
    for (int i = 0; i < 16; i++) begin
      if (i == 10) begin
        rst = 1'b1;
        wait_clk(1);
        checks++;
        if ({ram_en, ram_rw, ram_adrs, ram_din, miso, miso_oe, busy, done, frame_err} !== RESET_VEC) begin
          failures++;
          $display("FAIL midframe_reset: got %05h, required %05h",
                   {ram_en, ram_rw, ram_adrs, ram_din, miso, miso_oe, busy, done, frame_err}, RESET_VEC);
        end
        rst = 1'b0;
      end
      mosi = frame[15-i];
      wait_clk(10);
      sclk = 1'b1;
      wait_clk(10);
      sclk = 1'b0;
    end
    wait_clk(10);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clk(20);
    checks++;
    if (en_count - e0 != 0 || err_count - f0 != 0) begin
      failures++;
      $display("FAIL midframe_discard: ram_en=%0d frame_err=%0d, required 0 0", en_count - e0, err_count - f0);
    end
    exp_acc.push_back('{1'b1, 4'h0, 8'h00});
    exp_rd.push_back(8'h10);
    spi_xfer({8'h80, 24'h0}, 16, 20, rx);
    e = exp_rd.pop_front();
    checks++;
    if (rx[23:16] !== e) begin
      failures++;
      $display("FAIL post_reset_read0: got %02h, required %02h", rx[23:16], e);
    end
    exp_acc.push_back('{1'b1, 4'h1, 8'h00});
    exp_rd.push_back(8'h11);
    spi_xfer({8'h81, 24'h0}, 16, 20, rx);
    e = exp_rd.pop_front();
    checks++;
    if (rx[23:16] !== e) begin
      failures++;
      $display("FAIL post_reset_read1: got %02h, required %02h", rx[23:16], e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rx;
    logic [7:0]  e;
    exp_acc.push_back('{1'b0, 4'h9, 8'hC3});
    spi_xfer({8'h09, 8'hC3, 16'h0}, 16, 5, rx);
    exp_acc.push_back('{1'b1, 4'h9, 8'h00});
    exp_rd.push_back(8'hC3);
    spi_xfer({8'h89, 24'h0}, 16, 5, rx);
    e = exp_rd.pop_front();
    checks++;
    if (rx[23:16] !== e) begin
      failures++;
      $display("FAIL back_to_back: got %02h, required %02h", rx[23:16], e);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_all_addresses();
    test_abort();
    test_busy_oe();
    test_long_read();
    test_reserved();
    test_reset_midframe();
    test_back_to_back();
    wait_clk(20);
    checks++;
    if (exp_acc.size() != 0 || exp_rd.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d accesses and %0d reads outstanding, required 0 0",
               exp_acc.size(), exp_rd.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
